// File: rtl/spi_slave_rx_if.sv
// SPI pin and output-FIFO handshake bundle for spi_slave_rx.
// The slave modport is the receiver side; master is the host/consumer side.
interface spi_slave_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          spi_sclk_in;
    logic                          spi_mosi_in;
    logic                          spi_cs_n_in;
    logic [DATA_WIDTH-1:0]         data_out;
    logic                          data_first_out;
    logic                          data_valid_out;
    logic                          data_ready_in;
    logic                          frame_end_out;
    logic                          overrun_out;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level_out;

    modport slave (
        input  spi_sclk_in, spi_mosi_in, spi_cs_n_in, data_ready_in,
        output data_out, data_first_out, data_valid_out, frame_end_out,
               overrun_out, fifo_level_out
    );

    modport master (
        output spi_sclk_in, spi_mosi_in, spi_cs_n_in, data_ready_in,
        input  data_out, data_first_out, data_valid_out, frame_end_out,
               overrun_out, fifo_level_out
    );
endinterface

// File: rtl/spi_slave_rx.sv
// Parametrised SPI slave receiver: synchronised pins, IDLE/ACTIVE frame tracking,
// word assembly and a first-word-fall-through output FIFO with overrun flag.
//
// state  | meaning
// IDLE   | cs_n high; sample edges ignored
// ACTIVE | cs_n low; shifting bits into the current word
module spi_slave_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    spi_slave_rx_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   LVL_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic          SCLK_IDLE = (CPOL != 0);
    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    logic [0:0]             r_state;
    logic [CW-1:0]          r_bit_cnt;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic                   r_first_pend;
    logic                   r_push_pend;
    logic [DATA_WIDTH-1:0]  r_push_data;
    logic                   r_push_first;
    logic                   r_frame_end;

    logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic                   r_first_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_level;
    logic                   r_overrun;
    logic [DATA_WIDTH-1:0]  r_hold_data;
    logic                   r_hold_first;

    logic                   w_sclk_cur;
    logic                   w_mosi;
    logic                   w_cs_cur;
    logic                   w_sample;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_frame_start;
    logic [DATA_WIDTH-1:0]  w_shift_next;
    logic                   w_valid;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;

    // Idle-level reset values keep the first post-reset cycles free of false edges.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_prev <= SCLK_IDLE;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.spi_sclk_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi_in};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n_in};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_cur    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi        = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_cur      = r_cs_sync[SYNC_STAGES-1];
    assign w_sample      = (CPOL == CPHA) ? (w_sclk_cur & ~r_sclk_prev)
                                          : (~w_sclk_cur & r_sclk_prev);
    assign w_cs_fall     = ~w_cs_cur & r_cs_prev;
    assign w_cs_rise     = w_cs_cur & ~r_cs_prev;
    assign w_frame_start = (r_state == ST_IDLE) && w_cs_fall;

    always_comb begin
        w_shift_next = r_shift;
        if (MSB_FIRST != 0) begin
            w_shift_next = {r_shift[DATA_WIDTH-2:0], w_mosi};
        end else begin
            w_shift_next = {w_mosi, r_shift[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_first_pend <= 1'b0;
            r_push_pend  <= 1'b0;
            r_push_data  <= '0;
            r_push_first <= 1'b0;
            r_frame_end  <= 1'b0;
        end else begin
            r_frame_end <= 1'b0;
            r_push_pend <= 1'b0;
            if (r_push_pend) begin
                r_first_pend <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_state      <= ST_ACTIVE;
                        r_bit_cnt    <= '0;
                        r_first_pend <= 1'b1;
                    end
                end
                default: begin
                    // A partial word is simply abandoned when the frame closes.
                    if (w_cs_rise) begin
                        r_state     <= ST_IDLE;
                        r_frame_end <= 1'b1;
                        r_bit_cnt   <= '0;
                    end else if (w_sample) begin
                        r_shift <= w_shift_next;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt    <= '0;
                            r_push_pend  <= 1'b1;
                            r_push_data  <= w_shift_next;
                            r_push_first <= r_first_pend;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_ONE;
                        end
                    end
                end
            endcase
        end
    end

    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == FULL_LVL);
    assign w_pop   = w_valid && bus.data_ready_in;
    assign w_push  = r_push_pend && (!w_full || w_pop);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i]       <= '0;
                r_first_mem[i] <= 1'b0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overrun    <= 1'b0;
            r_hold_data  <= '0;
            r_hold_first <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr]       <= r_push_data;
                r_first_mem[r_wr_ptr] <= r_push_first;
                r_wr_ptr              <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (w_frame_start) begin
                r_overrun <= 1'b0;
            end
            if (r_push_pend && !w_push) begin
                r_overrun <= 1'b1;
            end
            // Remember the head so data_out stays put once the FIFO drains.
            if (w_valid) begin
                r_hold_data  <= r_mem[r_rd_ptr];
                r_hold_first <= r_first_mem[r_rd_ptr];
            end
        end
    end

    assign bus.data_out       = w_valid ? r_mem[r_rd_ptr] : r_hold_data;
    assign bus.data_first_out = w_valid ? r_first_mem[r_rd_ptr] : r_hold_first;
    assign bus.data_valid_out = w_valid;
    assign bus.frame_end_out  = r_frame_end;
    assign bus.overrun_out    = r_overrun;
    assign bus.fifo_level_out = r_level;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: four instances (modes 0..3, one 12-bit LSB-first)
// driven by a bit-level SPI host model; a negedge monitor pops expected words.
module tb_spi_slave_rx;
    logic clk_in = 1'b0;
    logic rst_n_in;
    always #5 clk_in = ~clk_in;

    logic        sclk [4];
    logic        mosi [4];
    logic        csn  [4];
    logic        rdy  [4];
    logic [31:0] dout [4];
    logic        dfirst [4];
    logic        dvalid [4];
    logic        fend [4];
    logic        ovr  [4];
    logic [2:0]  lvl  [4];

    int width_c [4] = '{8, 8, 8, 12};
    int msb_c   [4] = '{1, 1, 1, 0};
    int cpol_c  [4] = '{0, 0, 1, 1};
    int cpha_c  [4] = '{0, 1, 0, 1};

    int          vectors = 0;
    int          miscompares = 0;
    logic [32:0] exp_q [4][$];
    int          mlvl [4];
    bit          ovr_exp [4];
    int          fend_cnt [4];
    int          fend_exp [4];
    int          tx_words[$];
    int          tx_exps[$];
    bit          bitq[$];
    logic [32:0] e;

    spi_slave_rx_if #(.DATA_WIDTH(8),  .FIFO_DEPTH(4)) if0 ();
    spi_slave_rx_if #(.DATA_WIDTH(8),  .FIFO_DEPTH(4)) if1 ();
    spi_slave_rx_if #(.DATA_WIDTH(8),  .FIFO_DEPTH(4)) if2 ();
    spi_slave_rx_if #(.DATA_WIDTH(12), .FIFO_DEPTH(4)) if3 ();

    spi_slave_rx #(.DATA_WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .FIFO_DEPTH(4), .SYNC_STAGES(2))
        u_dut0 (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(if0));
    spi_slave_rx #(.DATA_WIDTH(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .FIFO_DEPTH(4), .SYNC_STAGES(2))
        u_dut1 (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(if1));
    spi_slave_rx #(.DATA_WIDTH(8), .CPOL(1), .CPHA(0), .MSB_FIRST(1), .FIFO_DEPTH(4), .SYNC_STAGES(2))
        u_dut2 (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(if2));
    spi_slave_rx #(.DATA_WIDTH(12), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .FIFO_DEPTH(4), .SYNC_STAGES(2))
        u_dut3 (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(if3));

    assign if0.spi_sclk_in = sclk[0]; assign if0.spi_mosi_in = mosi[0];
    assign if0.spi_cs_n_in = csn[0];  assign if0.data_ready_in = rdy[0];
    assign if1.spi_sclk_in = sclk[1]; assign if1.spi_mosi_in = mosi[1];
    assign if1.spi_cs_n_in = csn[1];  assign if1.data_ready_in = rdy[1];
    assign if2.spi_sclk_in = sclk[2]; assign if2.spi_mosi_in = mosi[2];
    assign if2.spi_cs_n_in = csn[2];  assign if2.data_ready_in = rdy[2];
    assign if3.spi_sclk_in = sclk[3]; assign if3.spi_mosi_in = mosi[3];
    assign if3.spi_cs_n_in = csn[3];  assign if3.data_ready_in = rdy[3];

    assign dout[0] = {24'd0, if0.data_out}; assign dout[1] = {24'd0, if1.data_out};
    assign dout[2] = {24'd0, if2.data_out}; assign dout[3] = {20'd0, if3.data_out};
    assign dfirst[0] = if0.data_first_out; assign dfirst[1] = if1.data_first_out;
    assign dfirst[2] = if2.data_first_out; assign dfirst[3] = if3.data_first_out;
    assign dvalid[0] = if0.data_valid_out; assign dvalid[1] = if1.data_valid_out;
    assign dvalid[2] = if2.data_valid_out; assign dvalid[3] = if3.data_valid_out;
    assign fend[0] = if0.frame_end_out; assign fend[1] = if1.frame_end_out;
    assign fend[2] = if2.frame_end_out; assign fend[3] = if3.frame_end_out;
    assign ovr[0] = if0.overrun_out; assign ovr[1] = if1.overrun_out;
    assign ovr[2] = if2.overrun_out; assign ovr[3] = if3.overrun_out;
    assign lvl[0] = if0.fifo_level_out; assign lvl[1] = if1.fifo_level_out;
    assign lvl[2] = if2.fifo_level_out; assign lvl[3] = if3.fifo_level_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Monitor: every accepted head word must match the oldest expectation.
    always @(negedge clk_in) begin
        for (int i = 0; i < 4; i++) begin
            if (fend[i] === 1'b1) fend_cnt[i]++;
            if (dvalid[i] === 1'b1 && rdy[i] === 1'b1) begin
                vectors++;
                if (exp_q[i].size() == 0) begin
                    miscompares++;
                    $display("FAIL pop_dut%0d unexpected word actual=%h required=none", i, dout[i]);
                end else begin
                    e = exp_q[i].pop_front();
                    mlvl[i]--;
                    if ({dfirst[i], dout[i]} !== e) begin
                        miscompares++;
                        $display("FAIL pop_dut%0d actual first=%0d data=%h required first=%0d data=%h",
                                 i, dfirst[i], dout[i], e[32], e[31:0]);
                    end
                end
            end
        end
    end

    // Host: one bit per 8 clk_in cycles; pop_bit pulses ready so it lands on that word's push cycle.
    task automatic drive_bits(input int id, input int hcpol, input int hcpha, input int pop_bit);
        logic idle_lvl;
        idle_lvl = (hcpol != 0);
        for (int i = 0; i < bitq.size(); i++) begin
            if (hcpha == 0) begin
                mosi[id] = bitq[i];
                step(4);
                sclk[id] = ~idle_lvl;
                if (i == pop_bit) begin
                    step(3); rdy[id] = 1'b1; step(1); rdy[id] = 1'b0;
                end else begin
                    step(4);
                end
                sclk[id] = idle_lvl;
            end else begin
                sclk[id] = ~idle_lvl;
                mosi[id] = bitq[i];
                step(4);
                sclk[id] = idle_lvl;
                step(4);
            end
        end
        mosi[id] = 1'b0;
    endtask

    task automatic send_frame(input int id, input int hcpol, input int hcpha, input bit drain,
                              input int pop_word, input int partial_bits, input int partial_word);
        int w_len;
        int w;
        int pop_bit;
        bit first;
        w_len   = width_c[id];
        first   = 1'b1;
        pop_bit = (pop_word >= 0) ? (pop_word + 1) * w_len - 1 : -1;
        ovr_exp[id] = 1'b0;
        for (int k = 0; k < tx_words.size(); k++) begin
            if (!drain && mlvl[id] >= 4 && k != pop_word) begin
                ovr_exp[id] = 1'b1;
            end else begin
                exp_q[id].push_back({first, 32'(tx_exps[k])});
                mlvl[id]++;
            end
            first = 1'b0;
        end
        bitq.delete();
        for (int k = 0; k <= tx_words.size(); k++) begin
            int nb;
            w  = (k < tx_words.size()) ? tx_words[k] : partial_word;
            nb = (k < tx_words.size()) ? w_len : partial_bits;
            for (int i = 0; i < nb; i++) begin
                int sh;
                sh = (msb_c[id] != 0) ? (w_len - 1 - i) : i;
                bitq.push_back(bit'((w >> sh) & 1));
            end
        end
        csn[id] = 1'b0;
        step(8);
        drive_bits(id, hcpol, hcpha, pop_bit);
        step(8);
        csn[id] = 1'b1;
        fend_exp[id]++;
        step(8);
    endtask

    task automatic rand_frames(input int id, input int nframes);
        int mask;
        int w;
        mask = (1 << width_c[id]) - 1;
        for (int f = 0; f < nframes; f++) begin
            tx_words.delete(); tx_exps.delete();
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                w = int'($urandom) & mask;
                tx_words.push_back(w); tx_exps.push_back(w);
            end
            send_frame(id, cpol_c[id], cpha_c[id], 1'b1, -1, 0, 0);
        end
    endtask

    task automatic wait_empty(input int id);
        int t;
        t = 0;
        while ((exp_q[id].size() != 0 || dvalid[id] === 1'b1) && t < 3000) begin
            step(1);
            t++;
        end
        if (t >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_dut%0d timeout actual_pending=%0d required=0", id, exp_q[id].size());
        end
    endtask

    task automatic set_words(input int a, input int b, input int n);
        tx_words.delete(); tx_exps.delete();
        for (int k = 0; k < n; k++) begin
            tx_words.push_back(a + k * b); tx_exps.push_back(a + k * b);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sclk[i] = (cpol_c[i] != 0); mosi[i] = 1'b0; csn[i] = 1'b1; rdy[i] = 1'b0;
            mlvl[i] = 0; ovr_exp[i] = 1'b0; fend_cnt[i] = 0; fend_exp[i] = 0;
        end
        step(5);
        rst_n_in = 1'b1;
        step(5);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_valid%0d", i), 64'(dvalid[i]), 0);
            check($sformatf("reset_level%0d", i), 64'(lvl[i]), 0);
            check($sformatf("reset_data%0d", i), 64'({dfirst[i], dout[i]}), 0);
            check($sformatf("reset_flags%0d", i), 64'({fend[i], ovr[i]}), 0);
        end

        // Mode 0 two-word frame, then random traffic
        rdy[0] = 1'b1;
        tx_words = '{32'hA5, 32'h3C}; tx_exps = '{32'hA5, 32'h3C};
        send_frame(0, 0, 0, 1'b1, -1, 0, 0);
        rand_frames(0, 4);
        wait_empty(0);

        // Modes 1..3 with matching host
        for (int id = 1; id < 4; id++) begin
            rdy[id] = 1'b1;
            set_words((id == 3) ? 32'h5A3 : 32'h96, 0, 1);
            send_frame(id, cpol_c[id], cpha_c[id], 1'b1, -1, 0, 0);
            rand_frames(id, 3);
            wait_empty(id);
        end

        // Mode-0 host into mode-1 receiver: trailing-edge sampling sees each next bit
        tx_words = '{32'h96}; tx_exps = '{32'h2C};
        send_frame(1, 0, 0, 1'b1, -1, 0, 0);
        wait_empty(1);

        // 12-bit LSB-first word plus a 5-bit partial that must not be queued
        rdy[3] = 1'b0;
        set_words(32'h5A3, 0, 1);
        send_frame(3, 1, 1, 1'b0, -1, 5, int'($urandom));
        check("partial_level", 64'(lvl[3]), 64'(mlvl[3]));
        check("partial_valid", 64'(dvalid[3]), 1);
        rdy[3] = 1'b1;
        wait_empty(3);

        // Overrun: six words into a depth-4 FIFO with no consumer
        rdy[0] = 1'b0;
        set_words(1, 1, 6);
        send_frame(0, 0, 0, 1'b0, -1, 0, 0);
        check("ovr_level", 64'(lvl[0]), 64'(mlvl[0]));
        check("ovr_flag", 64'(ovr[0]), 64'(ovr_exp[0]));
        rdy[0] = 1'b1;
        wait_empty(0);
        check("ovr_sticky", 64'(ovr[0]), 1);
        rdy[0] = 1'b0;
        tx_words.delete(); tx_exps.delete();
        send_frame(0, 0, 0, 1'b0, -1, 0, 0);
        check("ovr_cleared", 64'(ovr[0]), 64'(ovr_exp[0]));

        // Full FIFO with a pop coinciding with the fifth push
        tx_words.delete(); tx_exps.delete();
        for (int k = 0; k < 5; k++) begin
            int w;
            w = int'($urandom_range(0, 255));
            tx_words.push_back(w); tx_exps.push_back(w);
        end
        send_frame(0, 0, 0, 1'b0, 4, 0, 0);
        check("full_pop_level", 64'(lvl[0]), 64'(mlvl[0]));
        check("full_pop_ovr", 64'(ovr[0]), 64'(ovr_exp[0]));
        rdy[0] = 1'b1;
        wait_empty(0);
        rand_frames(0, 3);
        wait_empty(0);

        // Reset mid-word with two words queued
        rdy[0] = 1'b0;
        tx_words.delete(); tx_exps.delete();
        tx_words.push_back(int'($urandom_range(0, 255))); tx_exps.push_back(tx_words[0]);
        tx_words.push_back(int'($urandom_range(0, 255))); tx_exps.push_back(tx_words[1]);
        send_frame(0, 0, 0, 1'b0, -1, 0, 0);
        check("prerst_level", 64'(lvl[0]), 64'(mlvl[0]));
        csn[0] = 1'b0;
        step(8);
        bitq.delete();
        for (int i = 0; i < 4; i++) bitq.push_back(bit'($urandom_range(0, 1)));
        drive_bits(0, 0, 0, -1);
        rst_n_in = 1'b0;
        #1;
        check("rst_valid", 64'(dvalid[0]), 0);
        check("rst_level", 64'(lvl[0]), 0);
        check("rst_data", 64'({dfirst[0], dout[0]}), 0);
        check("rst_flags", 64'({fend[0], ovr[0]}), 0);
        exp_q[0].delete(); mlvl[0] = 0; ovr_exp[0] = 1'b0;
        step(1);
        csn[0] = 1'b1;
        step(1);
        rst_n_in = 1'b1;
        step(8);
        rdy[0] = 1'b1;
        set_words(32'hFF, 0, 1);
        send_frame(0, 0, 0, 1'b1, -1, 0, 0);
        wait_empty(0);

        step(10);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("frame_end_count%0d", i), 64'(fend_cnt[i]), 64'(fend_exp[i]));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
Parametrised SPI slave receiver. Successor to the fixed mode-0, 8-bit, MSB-first byte receiver.
- Adds selectable CPOL/CPHA, word width and bit order.
- Adds input synchronisers, frame tracking and an output FIFO with valid/ready handshake and overrun detection.
- Sits between the external SPI host pins and the LED frame-buffer writer in the clk_in domain.

Parameters:
DATA_WIDTH, 8, bits per received word (2..32)
CPOL, 0, idle level of spi_sclk_in
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = first bit received lands in data_out[DATA_WIDTH-1]; 0 = lands in bit 0
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)
SYNC_STAGES, 2, flip-flop stages on sclk, mosi and cs_n (>=2)

Ports:
clk_in  input  1  system clock; must be >=4x spi_sclk_in frequency
rst_n_in  input  1  asynchronous active-low reset
spi_sclk_in  input  1  SPI clock, asynchronous
spi_mosi_in  input  1  SPI data in, asynchronous
spi_cs_n_in  input  1  SPI chip select, active low, asynchronous
data_out  output  DATA_WIDTH  FIFO head word
data_first_out  output  1  head word is the first word of its frame
data_valid_out  output  1  FIFO non-empty
data_ready_in  input  1  consumer accepts head word when high with data_valid_out
frame_end_out  output  1  one-cycle pulse on synchronised cs_n rising edge
overrun_out  output  1  sticky: a completed word was dropped because the FIFO was full
fifo_level_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: all outputs 0, FIFO empty, bit counter 0, state IDLE. Reset is asynchronous to every flop, including synchronisers.
- Synchronisation:
  - sclk, mosi and cs_n each pass through SYNC_STAGES flops.
  - Edges are detected from the last two synchronised sclk samples.
  - Mosi is sampled from the same pipeline stage as the sclk edge, so data and clock stay aligned.
- Sample edge:
  - Rising sclk when CPOL==CPHA.
  - Falling sclk when CPOL!=CPHA.
- State machine: IDLE, ACTIVE.
  - IDLE -> ACTIVE on synchronised cs_n falling. This clears the bit counter and sets first_pending. Sample edges in IDLE are ignored.
  - ACTIVE -> IDLE on synchronised cs_n rising. This pulses frame_end_out for one cycle and discards any partial word without writing it.
- Shifting, on each sample edge in ACTIVE:
  - MSB_FIRST=1: shift left, inserting mosi at bit 0.
  - MSB_FIRST=0: shift right, inserting mosi at bit DATA_WIDTH-1.
  - The bit counter increments and wraps to 0 after DATA_WIDTH-1.
- Word completion:
  - On the sample edge where the counter equals DATA_WIDTH-1, the completed word plus the first_pending flag is pushed on the next clk_in cycle.
  - first_pending clears on that push.
  - Latency: data_valid_out rises exactly 2 clk_in cycles after the cycle in which the last bit's edge is detected, when the FIFO was empty.
- FIFO:
  - First-word-fall-through. data_out and data_first_out reflect the head entry whenever data_valid_out=1.
  - Pop occurs when data_valid_out && data_ready_in.
  - data_out holds its value while data_valid_out=0.
- Full: a push while full with no simultaneous pop drops the word and sets overrun_out. Push plus pop in the same cycle when full both succeed, and the level is unchanged.
- Empty: data_ready_in while empty has no effect.
- Level counting: push plus pop in the same cycle leaves fifo_level_out unchanged. The pointers wrap modulo FIFO_DEPTH.
- overrun_out clears only on the next IDLE->ACTIVE transition or on reset.
- CS handling: cs_n deassertion does not flush the FIFO. Words already queued remain readable.
- Reset mid-frame: everything clears immediately, and queued words are lost.

Test Plan:
- Mode 0, DATA_WIDTH=8, MSB_FIRST=1, sclk=clk/8: send 0xA5, 0x3C in one frame with ready=1 -> data_out 0xA5 (first=1), then 0x3C (first=0); frame_end_out pulses once after cs_n rises.
- Modes 1, 2 and 3, each with CPOL/CPHA matched on the host model: send 0x96 -> data_out 0x96 in every mode. With a deliberate mode mismatch -> value differs (sanity check).
- MSB_FIRST=0, DATA_WIDTH=12: host shifts 0x5A3 LSB-first -> data_out 0x5A3. Deasserting cs_n after 5 bits of the next word -> no extra push; level stays 1.
- FIFO_DEPTH=4 with ready=0: send 6 bytes 0x01..0x06 -> level 4, overrun_out=1. Draining returns 0x01..0x04. A new cs_n falling edge clears overrun_out.
- Full FIFO with ready=1 asserted in the same cycle as a push -> no overrun; level stays 4. Output order is preserved across the pointer wrap.
- Assert rst_n_in low for 1 cycle mid-word with 2 words queued -> all outputs 0 and level 0. The next frame 0xFF is received correctly.
